// File: rtl/layer_input_loader.sv
// Serial-to-parallel loader: gathers NUM_INPUTS samples, strobes inputs_ready, then waits for
// layer_done. Optional WAIT-state watchdog enabled by defining LOADER_TIMEOUT_EN.
module layer_input_loader #(
  parameter int unsigned NUM_INPUTS     = 16,
  parameter int unsigned TIMEOUT_CYCLES = 1024,
  parameter int unsigned DATA_W         = 16
) (
  input  logic                                 clock,
  input  logic                                 reset,
  input  logic                                 in_valid,
  input  logic [DATA_W-1:0]                    in_data,
  input  logic                                 in_last,
  output logic                                 in_ready,
  output logic [NUM_INPUTS-1:0][DATA_W-1:0]    layer_inputs,
  output logic                                 inputs_ready,
  input  logic                                 layer_done,
  output logic                                 busy,
  output logic                                 frame_error,
  input  logic                                 err_clear,
  output logic                                 timeout
);

  localparam int unsigned CntW = (NUM_INPUTS > 1) ? $clog2(NUM_INPUTS) : 1;

  typedef enum logic [1:0] {StLoad, StFire, StWait} state_e;

  state_e                              state_q, state_d;
  logic [CntW-1:0]                     count_q, count_d;
  logic [NUM_INPUTS-1:0][DATA_W-1:0]   data_q, data_d;
  logic                                wait_first_q, wait_first_d;
  logic                                in_ready_q, in_ready_d;
  logic                                inputs_ready_q, inputs_ready_d;
  logic                                busy_q, busy_d;
  logic                                frame_error_q, frame_error_d;
  logic                                accept;
  logic                                tmo_hit;
  logic                                tmo_set;

  assign accept = in_valid && in_ready_q;

  always_comb begin
    state_d       = state_q;
    count_d       = count_q;
    data_d        = data_q;
    wait_first_d  = wait_first_q;
    frame_error_d = err_clear ? 1'b0 : frame_error_q;
    tmo_set       = 1'b0;

    unique case (state_q)
      StLoad: begin
        if (accept) begin
          data_d[count_q] = in_data;
          count_d         = count_q + CntW'(1);
          if (count_q == CntW'(NUM_INPUTS - 1)) begin
            // Over-long frame: surplus samples stay at the source since in_ready drops.
            if (!in_last) frame_error_d = 1'b1;
            state_d = StFire;
          end else if (in_last) begin
            for (int i = 0; i < int'(NUM_INPUTS); i++) begin
              if (CntW'(i) > count_q) data_d[i] = '0;
            end
            frame_error_d = 1'b1;
            state_d       = StFire;
          end
        end
      end
      StFire: begin
        count_d      = '0;
        wait_first_d = 1'b1;
        state_d      = StWait;
      end
      StWait: begin
        wait_first_d = 1'b0;
        // First WAIT cycle ignores layer_done so a stale level from the last frame is harmless.
        if (!wait_first_q && layer_done) begin
          state_d = StLoad;
        end else if (tmo_hit) begin
          tmo_set = 1'b1;
          state_d = StLoad;
        end
      end
      default: state_d = StLoad;
    endcase

    in_ready_d     = (state_d == StLoad);
    inputs_ready_d = (state_d == StFire);
    busy_d         = (state_d == StFire) || (state_d == StWait);
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q        <= StLoad;
      count_q        <= '0;
      data_q         <= '0;
      wait_first_q   <= 1'b0;
      in_ready_q     <= 1'b1;
      inputs_ready_q <= 1'b0;
      busy_q         <= 1'b0;
      frame_error_q  <= 1'b0;
    end else begin
      state_q        <= state_d;
      count_q        <= count_d;
      data_q         <= data_d;
      wait_first_q   <= wait_first_d;
      in_ready_q     <= in_ready_d;
      inputs_ready_q <= inputs_ready_d;
      busy_q         <= busy_d;
      frame_error_q  <= frame_error_d;
    end
  end

`ifdef LOADER_TIMEOUT_EN
  localparam int unsigned TmoW = $clog2(TIMEOUT_CYCLES + 1);

  logic [TmoW-1:0] tmo_cnt_q, tmo_cnt_d;
  logic            timeout_q, timeout_d;

  assign tmo_hit = (state_q == StWait) && (tmo_cnt_q == TmoW'(TIMEOUT_CYCLES - 1));

  always_comb begin
    tmo_cnt_d = tmo_cnt_q;
    if (state_q == StFire) begin
      tmo_cnt_d = '0;
    end else if (state_q == StWait) begin
      tmo_cnt_d = tmo_cnt_q + TmoW'(1);
    end
    timeout_d = err_clear ? 1'b0 : timeout_q;
    if (tmo_set) timeout_d = 1'b1;
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      tmo_cnt_q <= '0;
      timeout_q <= 1'b0;
    end else begin
      tmo_cnt_q <= tmo_cnt_d;
      timeout_q <= timeout_d;
    end
  end

  assign timeout = timeout_q;
`else
  assign tmo_hit = 1'b0;
  assign timeout = 1'b0;
`endif

  assign in_ready     = in_ready_q;
  assign inputs_ready = inputs_ready_q;
  assign busy         = busy_q;
  assign frame_error  = frame_error_q;
  assign layer_inputs = data_q;

endmodule

// File: tb/tb_layer_input_loader.sv
// Self-checking bench for layer_input_loader (NUM_INPUTS=4, TIMEOUT_CYCLES=8, Q8.8 samples).
module tb_layer_input_loader;

  localparam int unsigned N  = 4;
  localparam int unsigned DW = 16;

  typedef logic [N-1:0][DW-1:0] vec_t;

  logic          clock = 1'b0;
  logic          reset = 1'b0;
  logic          in_valid = 1'b0;
  logic [DW-1:0] in_data = '0;
  logic          in_last = 1'b0;
  logic          in_ready;
  vec_t          layer_inputs;
  logic          inputs_ready;
  logic          layer_done = 1'b0;
  logic          busy;
  logic          frame_error;
  logic          err_clear = 1'b0;
  logic          timeout;

  int   tests = 0;
  int   failed = 0;
  vec_t exp_q[$];
  logic prev_ir = 1'b0;

  layer_input_loader #(
    .NUM_INPUTS    (N),
    .TIMEOUT_CYCLES(8),
    .DATA_W        (DW)
  ) dut (
    .clock       (clock),
    .reset       (reset),
    .in_valid    (in_valid),
    .in_data     (in_data),
    .in_last     (in_last),
    .in_ready    (in_ready),
    .layer_inputs(layer_inputs),
    .inputs_ready(inputs_ready),
    .layer_done  (layer_done),
    .busy        (busy),
    .frame_error (frame_error),
    .err_clear   (err_clear),
    .timeout     (timeout)
  );

  always #5 clock = ~clock;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  function automatic vec_t mk(input logic [DW-1:0] a, b, c, d);
    mk = {d, c, b, a};
  endfunction

  // Scoreboard: every inputs_ready pulse pops the next expected vector.
  always @(negedge clock) begin
    if (reset && inputs_ready) begin
      tests++;
      if (exp_q.size() == 0) begin
        failed++;
        $display("FAIL unexpected_inputs_ready: got pulse, expected none (vec=%h)", layer_inputs);
      end else begin
        vec_t e;
        e = exp_q.pop_front();
        if (layer_inputs !== e) begin
          failed++;
          $display("FAIL vector: got %h expected %h", layer_inputs, e);
        end
      end
      if (prev_ir) begin
        tests++;
        failed++;
        $display("FAIL strobe_width: got 2+ cycle pulse, expected 1 cycle");
      end
    end
    prev_ir = reset && inputs_ready;
  end

  task automatic send(input logic [DW-1:0] d, input logic last);
    int n;
    in_valid = 1'b1;
    in_data  = d;
    in_last  = last;
    n = 0;
    while (!in_ready && n < 100) begin
      @(negedge clock);
      n++;
    end
    if (n >= 100) begin
      tests++;
      failed++;
      $display("FAIL send_wait: got in_ready=0 for 100 cycles, expected 1");
    end else begin
      @(negedge clock);
    end
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  // Called at the FIRE-cycle negedge; raises layer_done in the 2nd WAIT cycle.
  task automatic finish_frame();
    repeat (2) @(negedge clock);
    layer_done = 1'b1;
    @(negedge clock);
    layer_done = 1'b0;
    tests++;
    if (in_ready !== 1'b1 || busy !== 1'b0) begin
      failed++;
      $display("FAIL finish_frame: got in_ready=%b busy=%b, expected 1 0", in_ready, busy);
    end
  endtask

  task automatic check_fire(input string name, input logic fe);
    tests++;
    if (inputs_ready !== 1'b1 || busy !== 1'b1 || in_ready !== 1'b0 || frame_error !== fe) begin
      failed++;
      $display("FAIL %s_fire: got ir=%b busy=%b rdy=%b fe=%b, expected 1 1 0 %b",
               name, inputs_ready, busy, in_ready, frame_error, fe);
    end
  endtask

  task automatic test_reset();
    reset = 1'b0;
    repeat (2) @(negedge clock);
    tests++;
    if (in_ready !== 1'b1 || inputs_ready !== 1'b0 || busy !== 1'b0 || frame_error !== 1'b0 ||
        timeout !== 1'b0 || layer_inputs !== '0) begin
      failed++;
      $display("FAIL reset_state: got rdy=%b ir=%b busy=%b fe=%b to=%b vec=%h, expected 1 0 0 0 0 0",
               in_ready, inputs_ready, busy, frame_error, timeout, layer_inputs);
    end
    reset = 1'b1;
    @(negedge clock);
  endtask

  task automatic test_basic();
    exp_q.push_back(mk(16'h0100, 16'h0200, 16'h0300, 16'h0400));
    send(16'h0100, 1'b0);
    send(16'h0200, 1'b0);
    send(16'h0300, 1'b0);
    send(16'h0400, 1'b1);
    check_fire("basic", 1'b0);
    finish_frame();
  endtask

  task automatic test_done_hold();
    exp_q.push_back(mk(16'h0500, 16'h0600, 16'h0700, 16'h0800));
    send(16'h0500, 1'b0);
    send(16'h0600, 1'b0);
    send(16'h0700, 1'b0);
    layer_done = 1'b1;
    send(16'h0800, 1'b1);
    check_fire("done_hold", 1'b0);
    @(negedge clock);
    tests++;
    if (busy !== 1'b1 || in_ready !== 1'b0 || inputs_ready !== 1'b0) begin
      failed++;
      $display("FAIL wait1: got busy=%b rdy=%b ir=%b, expected 1 0 0", busy, in_ready, inputs_ready);
    end
    @(negedge clock);
    tests++;
    if (busy !== 1'b1 || in_ready !== 1'b0) begin
      failed++;
      $display("FAIL stale_done: got busy=%b rdy=%b, expected 1 0", busy, in_ready);
    end
    layer_done = 1'b0;
    repeat (5) begin
      @(negedge clock);
      tests++;
      if (busy !== 1'b1) begin
        failed++;
        $display("FAIL wait_hold: got busy=%b, expected 1", busy);
      end
    end
    layer_done = 1'b1;
    @(negedge clock);
    layer_done = 1'b0;
    tests++;
    if (in_ready !== 1'b1 || busy !== 1'b0) begin
      failed++;
      $display("FAIL done_return: got rdy=%b busy=%b, expected 1 0", in_ready, busy);
    end
  endtask

  task automatic test_short_frame();
    exp_q.push_back(mk(16'h0500, 16'h0600, 16'h0000, 16'h0000));
    send(16'h0500, 1'b0);
    send(16'h0600, 1'b1);
    check_fire("short", 1'b1);
    finish_frame();
    tests++;
    if (frame_error !== 1'b1) begin
      failed++;
      $display("FAIL short_sticky: got fe=%b, expected 1", frame_error);
    end
    err_clear = 1'b1;
    @(negedge clock);
    err_clear = 1'b0;
    tests++;
    if (frame_error !== 1'b0) begin
      failed++;
      $display("FAIL err_clear: got fe=%b, expected 0", frame_error);
    end
  endtask

  task automatic test_clear_vs_set();
    exp_q.push_back(mk(16'h2100, 16'h0000, 16'h0000, 16'h0000));
    err_clear = 1'b1;
    send(16'h2100, 1'b1);
    err_clear = 1'b0;
    check_fire("clear_vs_set", 1'b1);
    finish_frame();
    err_clear = 1'b1;
    @(negedge clock);
    err_clear = 1'b0;
  endtask

  task automatic test_long_frame();
    vec_t e;
    e = mk(16'h1100, 16'h1200, 16'h1300, 16'h1400);
    exp_q.push_back(e);
    send(16'h1100, 1'b0);
    send(16'h1200, 1'b0);
    send(16'h1300, 1'b0);
    send(16'h1400, 1'b0);
    check_fire("long", 1'b1);
    in_valid = 1'b1;
    in_data  = 16'h1500;
    repeat (4) begin
      @(negedge clock);
      tests++;
      if (in_ready !== 1'b0 || layer_inputs !== e) begin
        failed++;
        $display("FAIL long_pending: got rdy=%b vec=%h, expected 0 %h", in_ready, layer_inputs, e);
      end
    end
    in_valid   = 1'b0;
    layer_done = 1'b1;
    @(negedge clock);
    layer_done = 1'b0;
    tests++;
    if (in_ready !== 1'b1 || frame_error !== 1'b1) begin
      failed++;
      $display("FAIL long_return: got rdy=%b fe=%b, expected 1 1", in_ready, frame_error);
    end
    err_clear = 1'b1;
    @(negedge clock);
    err_clear = 1'b0;
  endtask

  task automatic test_reset_midframe();
    send(16'h3100, 1'b0);
    send(16'h3200, 1'b0);
    reset = 1'b0;
    #1;
    tests++;
    if (in_ready !== 1'b1 || inputs_ready !== 1'b0 || busy !== 1'b0 || layer_inputs !== '0) begin
      failed++;
      $display("FAIL async_reset: got rdy=%b ir=%b busy=%b vec=%h, expected 1 0 0 0",
               in_ready, inputs_ready, busy, layer_inputs);
    end
    repeat (2) @(negedge clock);
    reset = 1'b1;
    exp_q.push_back(mk(16'h0700, 16'h0800, 16'h0900, 16'h0a00));
    send(16'h0700, 1'b0);
    send(16'h0800, 1'b0);
    send(16'h0900, 1'b0);
    send(16'h0a00, 1'b1);
    check_fire("after_reset", 1'b0);
    finish_frame();
  endtask

  task automatic test_timeout();
    exp_q.push_back(mk(16'h4100, 16'h4200, 16'h4300, 16'h4400));
    send(16'h4100, 1'b0);
    send(16'h4200, 1'b0);
    send(16'h4300, 1'b0);
    send(16'h4400, 1'b1);
    check_fire("timeout", 1'b0);
`ifdef LOADER_TIMEOUT_EN
    repeat (8) begin
      @(negedge clock);
      tests++;
      if (busy !== 1'b1 || timeout !== 1'b0) begin
        failed++;
        $display("FAIL tmo_wait: got busy=%b to=%b, expected 1 0", busy, timeout);
      end
    end
    @(negedge clock);
    tests++;
    if (timeout !== 1'b1 || in_ready !== 1'b1 || busy !== 1'b0) begin
      failed++;
      $display("FAIL tmo_fire: got to=%b rdy=%b busy=%b, expected 1 1 0", timeout, in_ready, busy);
    end
    err_clear = 1'b1;
    @(negedge clock);
    err_clear = 1'b0;
    tests++;
    if (timeout !== 1'b0) begin
      failed++;
      $display("FAIL tmo_clear: got to=%b, expected 0", timeout);
    end
`else
    repeat (20) begin
      @(negedge clock);
      tests++;
      if (busy !== 1'b1 || timeout !== 1'b0) begin
        failed++;
        $display("FAIL no_tmo_wait: got busy=%b to=%b, expected 1 0", busy, timeout);
      end
    end
    layer_done = 1'b1;
    @(negedge clock);
    layer_done = 1'b0;
    tests++;
    if (in_ready !== 1'b1) begin
      failed++;
      $display("FAIL no_tmo_return: got rdy=%b, expected 1", in_ready);
    end
`endif
  endtask

  initial begin
    test_reset();
    test_basic();
    test_done_hold();
    test_short_frame();
    test_clear_vs_set();
    test_long_frame();
    test_reset_midframe();
    test_timeout();
    repeat (3) @(negedge clock);
    tests++;
    if (exp_q.size() != 0) begin
      failed++;
      $display("FAIL scoreboard_drain: got %0d pending vectors, expected 0", exp_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
